// File: rtl/spi_target_x1.sv
// SPI mode-0 target with TX/RX holding registers, fully oversampled in clk_spi.
// Define SPI_TGT_LSB_FIRST_EN to shift both directions LSB-first (default MSB-first).
module spi_target_x1 #(
    parameter int          DW          = 8,
    parameter logic [31:0] TX_IDLE     = 32'hFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk_spi,
    input  logic          rst_spi,
    input  logic          enable,
    input  logic          spi_sck,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ack,
    output logic          rx_overrun,
    output logic          tx_underrun,
    output logic          frame_abort,
    output logic          busy
);

    localparam int            CW        = $clog2(DW);
    localparam logic [DW-1:0] IDLE_WORD = TX_IDLE[DW-1:0];
    localparam logic [CW-1:0] LAST_BIT  = CW'(DW - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

`ifdef SPI_TGT_LSB_FIRST_EN
    localparam int OUT_BIT = 0;

    function automatic logic [DW-1:0] tx_shift(input logic [DW-1:0] v);
        return {1'b0, v[DW-1:1]};
    endfunction

    function automatic logic [DW-1:0] rx_shift(input logic [DW-1:0] v, input logic b);
        return {b, v[DW-1:1]};
    endfunction
`else
    localparam int OUT_BIT = DW - 1;

    function automatic logic [DW-1:0] tx_shift(input logic [DW-1:0] v);
        return {v[DW-2:0], 1'b0};
    endfunction

    function automatic logic [DW-1:0] rx_shift(input logic [DW-1:0] v, input logic b);
        return {v[DW-2:0], b};
    endfunction
`endif

    // ---------------- input synchronizers and edge strobes ----------------
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_d, cs_d, sync_live, cs_armed;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_spi) begin
        if (rst_spi) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            sync_live <= 1'b0;
            cs_armed  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            sync_live <= 1'b1;
            // The cs_n preset would fake a falling edge if reset ends mid-frame;
            // only engage after a genuine high level has reached the chain.
            if (sync_live && cs_sync[0]) cs_armed <= 1'b1;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d & cs_armed;
    assign cs_rise  = cs_s & ~cs_d;

    // ---------------- protocol state ----------------
    state_t        state, state_nx;
    logic [CW-1:0] bit_cnt, bit_cnt_nx;
    logic [DW-1:0] tx_sh, tx_sh_nx, rx_sh, rx_sh_nx;
    logic [DW-1:0] hold_data, hold_data_nx, rx_data_nx;
    logic          hold_full, hold_full_nx, rx_valid_nx;
    logic          miso_nx, miso_oe_nx;
    logic          rx_overrun_nx, tx_underrun_nx, frame_abort_nx;
    logic          reload;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx       = state;
        bit_cnt_nx     = bit_cnt;
        tx_sh_nx       = tx_sh;
        rx_sh_nx       = rx_sh;
        hold_data_nx   = hold_data;
        hold_full_nx   = hold_full;
        rx_data_nx     = rx_data;
        rx_valid_nx    = rx_valid;
        rx_overrun_nx  = 1'b0;
        tx_underrun_nx = 1'b0;
        frame_abort_nx = 1'b0;
        reload         = 1'b0;

        if (tx_valid && !hold_full) begin
            hold_full_nx = 1'b1;
            hold_data_nx = tx_data;
        end
        if (rx_ack) rx_valid_nx = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                if (cs_fall && enable) begin
                    reload   = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    state_nx   = IDLE;
                    bit_cnt_nx = '0;
                end else if (cs_rise) begin
                    state_nx   = IDLE;
                    bit_cnt_nx = '0;
                    if (bit_cnt != '0) frame_abort_nx = 1'b1;
                end else if (sck_rise) begin
                    rx_sh_nx = rx_shift(rx_sh, mosi_s);
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nx = '0;
                        reload     = 1'b1;
                        if (!rx_valid || rx_ack) begin
                            rx_data_nx  = rx_sh_nx;
                            rx_valid_nx = 1'b1;
                        end else begin
                            rx_overrun_nx = 1'b1;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end
                end else if (sck_fall && bit_cnt != '0) begin
                    // Skipped at bit 0 so a freshly loaded first bit survives the first fall.
                    tx_sh_nx = tx_shift(tx_sh);
                end
            end
            default: state_nx = IDLE;
        endcase

        // A load from tx_valid needs an empty register, consumption needs a full one.
        if (reload) begin
            if (hold_full) begin
                tx_sh_nx     = hold_data;
                hold_full_nx = 1'b0;
            end else begin
                tx_sh_nx       = IDLE_WORD;
                tx_underrun_nx = 1'b1;
            end
        end

        miso_oe_nx = (state_nx == ACTIVE);
        miso_nx    = (state_nx == ACTIVE) ? tx_sh_nx[OUT_BIT] : 1'b0;
    end

    always_ff @(posedge clk_spi) begin
        if (rst_spi) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            tx_sh       <= tx_sh_nx;
            rx_sh       <= rx_sh_nx;
            hold_data   <= hold_data_nx;
            hold_full   <= hold_full_nx;
            rx_data     <= rx_data_nx;
            rx_valid    <= rx_valid_nx;
            spi_miso    <= miso_nx;
            spi_miso_oe <= miso_oe_nx;
            rx_overrun  <= rx_overrun_nx;
            tx_underrun <= tx_underrun_nx;
            frame_abort <= frame_abort_nx;
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_target_x1.sv
// Randomized scoreboard bench for spi_target_x1: an SPI initiator drives frames,
// independent monitors check MISO words, RX handshakes and status pulse counts.
module tb_spi_target_x1;

    localparam int            DW     = 8;
    localparam int            SYNC   = 2;
    localparam int            HALF   = 4;
    localparam logic [DW-1:0] IDLE_W = 8'hFF;

    typedef enum logic [1:0] {ACK_AUTO, ACK_NONE, ACK_FORCED} ack_mode_t;

    logic          clk_spi  = 1'b0;
    logic          rst_spi  = 1'b1;
    logic          enable   = 1'b1;
    logic          spi_sck  = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ack   = 1'b0;
    logic          rx_overrun, tx_underrun, frame_abort, busy;

    spi_target_x1 #(.DW(DW), .TX_IDLE(32'hFF), .SYNC_STAGES(SYNC)) dut (
        .clk_spi(clk_spi), .rst_spi(rst_spi), .enable(enable),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk_spi = ~clk_spi;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk_spi) cyc <= cyc + 1;

    logic [DW-1:0] exp_miso[$], exp_rx[$], tx_q[$];
    int        cnt_und = 0, cnt_ovr = 0, cnt_abt = 0;
    int        exp_und = 0, exp_ovr = 0, exp_abt = 0;
    ack_mode_t ack_mode = ACK_AUTO;
    int        force_ack_cyc = -1;
    logic      rdy_prev = 1'b0;
    logic [DW-1:0] mword = '0;
    int        mbits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_spi);
    endtask

    // Consumer + RX scoreboard + pulse counters, all sampled at the falling clock edge.
    initial forever begin
        @(negedge clk_spi);
        if (tx_underrun) cnt_und++;
        if (rx_overrun)  cnt_ovr++;
        if (frame_abort) cnt_abt++;
        case (ack_mode)
            ACK_AUTO:   rx_ack = rx_valid && ($urandom_range(0, 1) == 1);
            ACK_NONE:   rx_ack = 1'b0;
            default:    rx_ack = (cyc == force_ack_cyc);
        endcase
        if (rx_valid && rx_ack && !rst_spi) begin
            if (exp_rx.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rx_word: got 0x%0h, required no word", rx_data);
            end else begin
                check("rx_word", rx_data, exp_rx.pop_front());
            end
        end
    end

    // TX feeder: presents queued words on tx_data/tx_valid until accepted.
    initial forever begin
        @(negedge clk_spi);
        if (rst_spi) begin
            tx_valid = 1'b0;
        end else begin
            if (tx_valid && rdy_prev) tx_valid = 1'b0;
            if (!tx_valid && tx_q.size() > 0) begin
                tx_data  = tx_q.pop_front();
                tx_valid = 1'b1;
            end
        end
        rdy_prev = tx_ready;
    end

    // MISO monitor: assembles words as the initiator samples them on SCK rise.
    initial forever begin
        @(posedge spi_sck or posedge spi_cs_n);
        if (spi_cs_n) begin
            mbits = 0;
        end else begin
`ifdef SPI_TGT_LSB_FIRST_EN
            mword = {spi_miso, mword[DW-1:1]};
`else
            mword = {mword[DW-2:0], spi_miso};
`endif
            mbits++;
            if (mbits == DW) begin
                mbits = 0;
                check("miso_oe_in_word", spi_miso_oe, 1);
                if (exp_miso.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL miso_word: got 0x%0h, required no word", mword);
                end else begin
                    check("miso_word", mword, exp_miso.pop_front());
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit force_last);
        for (int i = 0; i < nbits; i++) begin
`ifdef SPI_TGT_LSB_FIRST_EN
            spi_mosi = w[i];
`else
            spi_mosi = w[DW-1-i];
`endif
            wait_cyc(HALF);
            spi_sck = 1'b1;
            if (force_last && i == DW - 1) force_ack_cyc = cyc + SYNC;
            wait_cyc(HALF);
            spi_sck = 1'b0;
        end
    endtask

    // Reference model: words go out in queue order, then TX_IDLE; every frame start
    // and every completed word takes one word from the holding register.
    task automatic run_frame(input logic [DW-1:0] txw[$], input logic [DW-1:0] rxw[$],
                             input bit force_last);
        int n = rxw.size();
        int k = txw.size();
        for (int j = 0; j < n; j++) exp_miso.push_back(j < k ? txw[j] : IDLE_W);
        exp_und += n + 1 - k;
        if (ack_mode == ACK_NONE) begin
            exp_rx.push_back(rxw[0]);
            exp_ovr += n - 1;
        end else begin
            foreach (rxw[j]) exp_rx.push_back(rxw[j]);
        end
        foreach (txw[j]) tx_q.push_back(txw[j]);
        if (k > 0) begin
            for (int t = 0; t < 50 && tx_ready; t++) wait_cyc(1);
            check("tx_preload", tx_ready, 0);
        end
        spi_cs_n = 1'b0;
        wait_cyc(8);
        check("busy_in_frame", busy, 1);
        check("oe_in_frame", spi_miso_oe, 1);
        for (int j = 0; j < n; j++) send_word(rxw[j], DW, force_last && j == n - 1);
        wait_cyc(HALF);
        check("tx_ready_after_frame", tx_ready, 1);
        spi_cs_n = 1'b1;
        wait_cyc(10);
    endtask

    task automatic drain_and_count(input string tag);
        ack_mode = ACK_AUTO;
        for (int t = 0; t < 100 && rx_valid; t++) wait_cyc(1);
        check({tag, "_rx_drained"}, rx_valid, 0);
        check({tag, "_underruns"}, cnt_und, exp_und);
        check({tag, "_overruns"}, cnt_ovr, exp_ovr);
        check({tag, "_aborts"}, cnt_abt, exp_abt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, spi_miso, 0);
        check({tag, "_oe"}, spi_miso_oe, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pulses"}, {rx_overrun, tx_underrun, frame_abort}, 0);
    endtask

    initial begin
        logic [DW-1:0] txw[$], rxw[$];

        wait_cyc(3);
        check_reset_values("reset");
        rst_spi = 1'b0;
        wait_cyc(6);

        // Basic exchange: A5 out, 3C in.
        txw = '{8'hA5}; rxw = '{8'h3C};
        run_frame(txw, rxw, 0);
        drain_and_count("basic");

        // Three-word burst with two queued TX words.
        txw = '{8'h11, 8'h22}; rxw = '{DW'($urandom), DW'($urandom), DW'($urandom)};
        run_frame(txw, rxw, 0);
        drain_and_count("burst");

        // Overrun: nobody acknowledges the first word.
        ack_mode = ACK_NONE;
        txw = '{}; rxw = '{8'h01, 8'h02};
        run_frame(txw, rxw, 0);
        check("ovr_rx_data", rx_data, 8'h01);
        check("ovr_rx_valid", rx_valid, 1);
        drain_and_count("overrun");

        // Ack in the completion cycle of word 2 accepts it without overrun.
        ack_mode = ACK_FORCED;
        run_frame(txw, rxw, 1);
        check("same_cycle_rx_data", rx_data, 8'h02);
        check("same_cycle_rx_valid", rx_valid, 1);
        force_ack_cyc = -1;
        drain_and_count("same_cycle_ack");

        // Mid-word abort after 5 bits.
        exp_und++; exp_abt++;
        spi_cs_n = 1'b0;
        wait_cyc(8);
        send_word(DW'($urandom), 5, 0);
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(SYNC + 2);
        check("abort_busy", busy, 0);
        check("abort_oe", spi_miso_oe, 0);
        check("abort_rx_valid", rx_valid, 0);
        wait_cyc(8);
        drain_and_count("abort");

        // Reset after bit 3, released with CS still low: no re-engagement.
        exp_und++;
        spi_cs_n = 1'b0;
        wait_cyc(8);
        send_word(8'hC3, 3, 0);
        rst_spi = 1'b1;
        wait_cyc(1);
        check_reset_values("mid_reset");
        wait_cyc(1);
        rst_spi = 1'b0;
        wait_cyc(4);
        send_word(8'h5A, 4, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_oe", spi_miso_oe, 0);
        check("post_reset_rx_valid", rx_valid, 0);
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(10);
        drain_and_count("reset");

        // Enable dropped mid-frame: immediate IDLE, no pulses.
        exp_und++;
        spi_cs_n = 1'b0;
        wait_cyc(8);
        send_word(8'h96, 3, 0);
        enable = 1'b0;
        wait_cyc(2);
        check("disable_busy", busy, 0);
        check("disable_oe", spi_miso_oe, 0);
        send_word(8'h69, 3, 0);
        check("disable_rx_valid", rx_valid, 0);
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(10);
        enable = 1'b1;
        wait_cyc(4);
        drain_and_count("disable");

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(1, 3);
            int k = $urandom_range(0, n);
            txw = '{}; rxw = '{};
            for (int j = 0; j < k; j++) txw.push_back(DW'($urandom));
            for (int j = 0; j < n; j++) rxw.push_back(DW'($urandom));
            run_frame(txw, rxw, 0);
            drain_and_count("random");
        end

        check("miso_queue_empty", exp_miso.size(), 0);
        check("rx_queue_empty", exp_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
